imem_server: RTL and testbench
==============================

# imem_server

Single-port SRAM responder for the 16-bit CPU. Answers the fetch stage's `pc` with an instruction every cycle and arbitrates the shared SRAM against data-memory requests from the MEM stage. While a data access owns the bus, it raises `stall_pc_o` and presents a NOP as the instruction. It sits between the IF/MEM stages and the board SRAM pins.

## Interface
- `NOP_INSTR`, 16'h0800, instruction word driven on `instr_o` whenever no valid fetch is available.
- `RAM_AW`, 18, SRAM address width; upper `RAM_AW-16` bits are driven 0.
- `WE_CYCLES`, 1, width of the write-enable low pulse in cycles; legal range 1..4.

- `CLK`  in  1  sole clock; all state changes on rising edge.
- `RST`  in  1  reset; synchronous, active-low.
- `pc_i`  in  16  fetch address from the fetch stage.
- `instr_o`  out  16  instruction for `pc_i`, or `NOP_INSTR`.
- `stall_pc_o`  out  1  fetch stage must hold `pc`.
- `mem_rd_i`  in  1  data read request; held until `mem_done_o`.
- `mem_wr_i`  in  1  data write request; held until `mem_done_o`.
- `mem_addr_i`  in  16  data word address.
- `mem_wdata_i`  in  16  write data.
- `mem_rdata_o`  out  16  registered read data; valid when `mem_done_o`=1, held until the next read completes.
- `mem_done_o`  out  1  one-cycle completion pulse.
- `ram_addr_o`  out  RAM_AW  SRAM address.
- `ram_data_o`  out  16  SRAM write data.
- `ram_data_oe_o`  out  1  1 = drive `ram_data_o` onto the SRAM data bus.
- `ram_data_i`  in  16  SRAM read data (asynchronous SRAM).
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o`  out  1 each  SRAM strobes, active-low.

## Operation
FSM states: FETCH, RD, WR_SETUP, WR_PULSE, WR_HOLD. The pulse counter is 2 bits.

**FETCH**
- Outputs: `ram_addr_o`=`pc_i`, ce_n=0, oe_n=0, we_n=1, data_oe=0.
- `instr_o`=`ram_data_i` (combinational pass-through). `stall_pc_o`=0.
- Transitions:
  - A request is ignored in any cycle where `mem_done_o`=1, because the requester is still dropping it.
  - If `mem_wr_i`=1, go to WR_SETUP. Write wins if both requests are asserted.
  - Else if `mem_rd_i`=1, go to RD.
  - Else stay in FETCH.

**RD**
- Outputs: `ram_addr_o`=`mem_addr_i`, ce_n=0, oe_n=0, we_n=1.
- At the edge: `mem_rdata_o`<=`ram_data_i`, `mem_done_o`<=1, go to FETCH.

**WR_SETUP**
- Outputs: addr=`mem_addr_i`, `ram_data_o`=`mem_wdata_i`, data_oe=1, ce_n=0, oe_n=1, we_n=1.
- Load counter with `WE_CYCLES-1`, go to WR_PULSE.

**WR_PULSE**
- Outputs: same as WR_SETUP but we_n=0.
- Decrement the counter; at 0, go to WR_HOLD.

**WR_HOLD**
- Outputs: we_n=1; addr and data still driven, data_oe=1.
- `mem_done_o`<=1, go to FETCH.

**All non-FETCH states:** `instr_o`=`NOP_INSTR`, `stall_pc_o`=1.

**Rules**
- `mem_done_o` is registered and high for exactly the first FETCH cycle after an access.
- A write to the address equal to `pc_i` is legal. The next FETCH returns the new word.
- `ram_we_n_o` and `ram_oe_n_o` are never both 0.
- `ram_data_oe_o`=1 only in the three WR states.

**Reset (`RST`=0 at an edge)**
- Next cycle: state=FETCH, counter=0, `mem_done_o`=0, `mem_rdata_o`=0.
- While `RST` is low, outputs are forced: ce_n=1, oe_n=1, we_n=1, data_oe=0, `instr_o`=`NOP_INSTR`, `stall_pc_o`=1.
- A reset in the middle of a write aborts it. we_n returns to 1 at the reset edge, and no `mem_done_o` is issued.

## Timing
- Fetch: zero-cycle latency, combinational from `pc_i` through the SRAM to `instr_o`. One instruction per cycle when there is no data traffic.
- Read, request seen at edge of cycle 0 (FETCH):
  - Cycle 1: RD, stall=1.
  - Cycle 2: FETCH, `mem_done_o`=1, `mem_rdata_o` valid.
  - Total: one stall cycle.
- Write, request seen at cycle 0:
  - Cycle 1: WR_SETUP.
  - Cycles 2..1+W: WR_PULSE.
  - Cycle 2+W: WR_HOLD.
  - Cycle 3+W: FETCH with `mem_done_o`=1.
  - Total: 2+W stall cycles.
- Address and data are stable for one full cycle before and after the we_n low window.
- Back-to-back requests: the earliest next acceptance is the cycle after the `mem_done_o` cycle.

## Test plan
- **Reset/fetch:** hold `RST`=0 for 2 cycles, then release. Model memory[5]=16'h6A12. With `pc_i`=5, expect `instr_o`=16'h6A12, stall=0, ce_n=0, oe_n=0, we_n=1, and `mem_done_o`=0. While `RST`=0, `instr_o`=16'h0800.
- **Read:** `mem_rd_i`=1, `mem_addr_i`=16'h4000, memory=16'hBEEF. Expect stall=1 for exactly 1 cycle, `instr_o`=16'h0800 during it, `mem_done_o` pulse in the next cycle with `mem_rdata_o`=16'hBEEF. Fetch then resumes at the unchanged `pc_i`.
- **Write, WE_CYCLES=2:** write 16'h1234 to 16'h0010. Expect we_n low for exactly 2 cycles, data_oe=1 for 4 cycles, stall high for 4 cycles, done in the 5th cycle. A subsequent fetch at `pc_i`=16'h0010 returns 16'h1234.
- **Simultaneous rd+wr:** expect the write path and one `mem_done_o`. Hold the request one extra cycle during the done cycle and expect no second access.
- **Reset mid-write, WE_CYCLES=4:** assert `RST`=0 in the second pulse cycle. Expect we_n=1 at the next edge, `mem_done_o` never pulses, and the state is FETCH after release.
- **Strobe invariant:** random rd/wr/pc traffic for 10k cycles. `ram_oe_n_o`=0 and `ram_we_n_o`=0 are never simultaneous, and `ram_data_oe_o`=1 only when we_n is low or in the setup/hold states.

Source files
------------

// File: rtl/imem_server_if.sv
// CPU-side bundle of the instruction/data memory server:
// fetch address and instruction plus the MEM-stage data handshake.
interface imem_server_if;
    logic [15:0] pc_i;
    logic [15:0] instr_o;
    logic        stall_pc_o;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [15:0] mem_addr_i;
    logic [15:0] mem_wdata_i;
    logic [15:0] mem_rdata_o;
    logic        mem_done_o;

    modport master (
        output pc_i, mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i,
        input  instr_o, stall_pc_o, mem_rdata_o, mem_done_o
    );

    modport slave (
        input  pc_i, mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i,
        output instr_o, stall_pc_o, mem_rdata_o, mem_done_o
    );
endinterface

// File: rtl/imem_server.sv
// Single-port async SRAM server: instruction fetch every cycle,
// with data reads/writes from the MEM stage stealing the bus.
module imem_server #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int          RAM_AW    = 18,
    parameter int          WE_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    imem_server_if.slave      bus,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [15:0]       ram_data_o,
    output logic              ram_data_oe_o,
    input  logic [15:0]       ram_data_i,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    typedef enum logic [2:0] {
        FETCH,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam logic [1:0] PULSE_LOAD = 2'(WE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [15:0] rdata_q;
    logic        rd_cap;
    logic [15:0] addr;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= FETCH;
            cnt_q   <= 2'd0;
            done_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (rd_cap) rdata_q <= ram_data_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        rd_cap        = 1'b0;
        addr          = bus.mem_addr_i;
        ram_data_o    = bus.mem_wdata_i;
        ram_data_oe_o = 1'b0;
        ram_ce_n_o    = 1'b0;
        ram_oe_n_o    = 1'b0;
        ram_we_n_o    = 1'b1;
        bus.instr_o    = NOP_INSTR;
        bus.stall_pc_o = 1'b1;

        unique case (state_q)
            FETCH: begin
                addr           = bus.pc_i;
                bus.instr_o    = ram_data_i;
                bus.stall_pc_o = 1'b0;
                // the requester is still dropping its request while done is high
                if (!done_q) begin
                    if (bus.mem_wr_i)      state_d = WR_SETUP;
                    else if (bus.mem_rd_i) state_d = RD;
                end
            end
            RD: begin
                rd_cap  = 1'b1;
                done_d  = 1'b1;
                state_d = FETCH;
            end
            WR_SETUP: begin
                ram_oe_n_o    = 1'b1;
                ram_data_oe_o = 1'b1;
                cnt_d         = PULSE_LOAD;
                state_d       = WR_PULSE;
            end
            WR_PULSE: begin
                ram_oe_n_o    = 1'b1;
                ram_we_n_o    = 1'b0;
                ram_data_oe_o = 1'b1;
                if (cnt_q == 2'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 2'd1;
            end
            WR_HOLD: begin
                ram_oe_n_o    = 1'b1;
                ram_data_oe_o = 1'b1;
                done_d        = 1'b1;
                state_d       = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // reset forces the pins idle at once, aborting any write pulse
        if (!RST) begin
            ram_ce_n_o     = 1'b1;
            ram_oe_n_o     = 1'b1;
            ram_we_n_o     = 1'b1;
            ram_data_oe_o  = 1'b0;
            bus.instr_o    = NOP_INSTR;
            bus.stall_pc_o = 1'b1;
        end
    end

    assign ram_addr_o      = RAM_AW'(addr);
    assign bus.mem_rdata_o = rdata_q;
    assign bus.mem_done_o  = done_q;

endmodule

// File: tb/tb_imem_server.sv
// Bench for imem_server: directed vector table, random traffic against a
// transaction-level memory model, and an abort-by-reset write sequence.
module tb_imem_server;

    localparam logic [15:0] NOP = 16'h0800;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    imem_server_if ifa ();
    imem_server_if ifb ();

    logic [17:0] addr_a, addr_b;
    logic [15:0] wd_a, wd_b, rd_a, rd_b;
    logic doe_a, doe_b, ce_a, ce_b, oe_a, oe_b, we_a, we_b;

    imem_server #(.NOP_INSTR(NOP), .RAM_AW(18), .WE_CYCLES(2)) dut_a (
        .CLK(clk), .RST(rst_a), .bus(ifa),
        .ram_addr_o(addr_a), .ram_data_o(wd_a), .ram_data_oe_o(doe_a),
        .ram_data_i(rd_a), .ram_ce_n_o(ce_a), .ram_oe_n_o(oe_a),
        .ram_we_n_o(we_a)
    );

    imem_server #(.NOP_INSTR(NOP), .RAM_AW(18), .WE_CYCLES(4)) dut_b (
        .CLK(clk), .RST(rst_b), .bus(ifb),
        .ram_addr_o(addr_b), .ram_data_o(wd_b), .ram_data_oe_o(doe_b),
        .ram_data_i(rd_b), .ram_ce_n_o(ce_b), .ram_oe_n_o(oe_b),
        .ram_we_n_o(we_b)
    );

    function automatic logic [15:0] init_word(input int i);
        if (i == 5)       return 16'h6A12;
        if (i == 'h4000)  return 16'hBEEF;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // asynchronous SRAM models, one per DUT
    logic [15:0] mem_a [65536];
    logic [15:0] mem_b [65536];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (!ce_a && !we_a && doe_a) mem_a[addr_a[15:0]] <= wd_a;
            if (!ce_b && !we_b && doe_b) mem_b[addr_b[15:0]] <= wd_b;
        end
    end

    assign rd_a = (!ce_a && !oe_a) ? mem_a[addr_a[15:0]] : 16'h0000;
    assign rd_b = (!ce_b && !oe_b) ? mem_b[addr_b[15:0]] : 16'h0000;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // strobe invariants on both DUTs every cycle
    always @(negedge clk) begin
        chk("a_oe_we_overlap", {31'd0, !oe_a && !we_a}, 32'd0);
        chk("b_oe_we_overlap", {31'd0, !oe_b && !we_b}, 32'd0);
        chk("a_doe_outside_wr",
            {31'd0, doe_a && (!oe_a || !ifa.stall_pc_o)}, 32'd0);
        chk("b_doe_outside_wr",
            {31'd0, doe_b && (!oe_b || !ifb.stall_pc_o)}, 32'd0);
    end

    // reference model: words written so far, otherwise the initial image
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(int'(a));
    endfunction

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        int          exp_stall;
        int          exp_we;
    } vec_t;

    task automatic do_op(input vec_t v);
        int stalls, wes, oes, nops;
        bit seen;
        logic [15:0] got;
        stalls = 0; wes = 0; oes = 0; nops = 0; seen = 0; got = '0;
        ifa.pc_i        = v.pc;
        ifa.mem_addr_i  = v.addr;
        ifa.mem_wdata_i = v.wdata;
        ifa.mem_rd_i    = v.rd;
        ifa.mem_wr_i    = v.wr;
        if (!v.rd && !v.wr) begin
            @(negedge clk);
            chk({v.name, "_instr"}, {16'd0, ifa.instr_o}, {16'd0, v.exp_data});
            chk({v.name, "_stall"}, {31'd0, ifa.stall_pc_o}, 32'd0);
            chk({v.name, "_done"}, {31'd0, ifa.mem_done_o}, 32'd0);
            chk({v.name, "_strobes"}, {29'd0, ce_a, oe_a, we_a}, 32'd1);
            @(posedge clk); #1;
            return;
        end
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clk);
            if (ifa.stall_pc_o) begin
                stalls++;
                if (ifa.instr_o !== NOP) nops++;
            end
            if (!we_a) wes++;
            if (doe_a) oes++;
            if (ifa.mem_done_o) begin
                seen = 1;
                got  = ifa.mem_rdata_o;
            end
            @(posedge clk); #1;
        end
        ifa.mem_rd_i = 1'b0;
        ifa.mem_wr_i = 1'b0;
        chk({v.name, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({v.name, "_stalls"}, stalls, v.exp_stall);
        chk({v.name, "_we_cycles"}, wes, v.exp_we);
        chk({v.name, "_doe_cycles"}, oes, v.wr ? v.exp_we + 2 : 0);
        chk({v.name, "_nop"}, nops, 0);
        if (!v.wr) chk({v.name, "_rdata"}, {16'd0, got}, {16'd0, v.exp_data});
        if (v.wr) ref_mem[int'(v.addr)] = v.wdata;
        @(negedge clk);
        chk({v.name, "_no_second"}, {30'd0, ifa.mem_done_o, ifa.stall_pc_o}, 32'd0);
        chk({v.name, "_resume"}, {16'd0, ifa.instr_o}, {16'd0, ref_rd(v.pc)});
        @(posedge clk); #1;
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{"fetch5",   0, 0, 16'h0005, 16'h0000, 16'h0000, 16'h6A12, 0, 0};
        tbl[1] = '{"read4000", 1, 0, 16'h0005, 16'h4000, 16'h0000, 16'hBEEF, 1, 0};
        tbl[2] = '{"write10",  0, 1, 16'h0007, 16'h0010, 16'h1234, 16'h0000, 4, 2};
        tbl[3] = '{"fetch10",  0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 0, 0};
        tbl[4] = '{"rdwr20",   1, 1, 16'h0020, 16'h0020, 16'hCAFE, 16'h0000, 4, 2};
        tbl[5] = '{"read20",   1, 0, 16'h0005, 16'h0020, 16'h0000, 16'hCAFE, 1, 0};
        tbl[6] = '{"fetch20",  0, 0, 16'h0020, 16'h0000, 16'h0000, 16'hCAFE, 0, 0};

        ifa.pc_i = 16'h0005; ifa.mem_rd_i = 0; ifa.mem_wr_i = 0;
        ifa.mem_addr_i = 0; ifa.mem_wdata_i = 0;
        ifb.pc_i = 16'h0000; ifb.mem_rd_i = 0; ifb.mem_wr_i = 0;
        ifb.mem_addr_i = 0; ifb.mem_wdata_i = 0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_instr", {16'd0, ifa.instr_o}, {16'd0, NOP});
            chk("rst_pins", {27'd0, ifa.stall_pc_o, ce_a, oe_a, we_a, doe_a},
                32'b11110);
        end
        @(posedge clk); #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_done", {31'd0, ifa.mem_done_o}, 32'd0);
        chk("rst_rdata", {16'd0, ifa.mem_rdata_o}, 32'd0);
        @(posedge clk); #1;

        foreach (tbl[i]) do_op(tbl[i]);

        for (int n = 0; n < 1500; n++) begin
            vec_t v;
            int kind;
            kind       = $urandom_range(0, 3);
            v.name     = "rand";
            v.pc       = 16'($urandom_range(0, 31));
            v.addr     = 16'($urandom_range(0, 31));
            v.wdata    = 16'($urandom);
            v.rd       = (kind == 1 || kind == 3);
            v.wr       = (kind == 2 || kind == 3);
            v.exp_stall = v.wr ? 4 : (v.rd ? 1 : 0);
            v.exp_we   = v.wr ? 2 : 0;
            v.exp_data = v.rd && !v.wr ? ref_rd(v.addr) : ref_rd(v.pc);
            do_op(v);
        end

        // abort a 4-cycle write pulse with reset
        begin
            bit low_seen;
            bit done_any;
            low_seen = 0;
            done_any = 0;
            ifb.mem_addr_i  = 16'h0030;
            ifb.mem_wdata_i = 16'h7777;
            ifb.mem_wr_i    = 1'b1;
            for (int c = 0; c < 10 && !low_seen; c++) begin
                @(negedge clk);
                if (!we_b) low_seen = 1;
                @(posedge clk); #1;
            end
            chk("abort_pulse_seen", {31'd0, low_seen}, 32'd1);
            chk("abort_pulse2_we", {31'd0, we_b}, 32'd0);
            rst_b = 1'b0;
            @(negedge clk);
            chk("abort_we_high", {31'd0, we_b}, 32'd1);
            chk("abort_instr", {16'd0, ifb.instr_o}, {16'd0, NOP});
            @(posedge clk); #1;
            ifb.mem_wr_i = 1'b0;
            rst_b = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (ifb.mem_done_o) done_any = 1;
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("abort_no_done", {31'd0, done_any}, 32'd0);
            chk("abort_fetch", {30'd0, ifb.stall_pc_o, we_b}, 32'd1);
            chk("abort_instr_after", {16'd0, ifb.instr_o}, {16'd0, init_word(0)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
